// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
// Shared constants for the waveform generator / measurement family.
//   SAMPLE_W  : width of an offset-binary sample
//   MIDSCALE  : offset-binary zero (midscale) code
//   sample_t  : sample type used across the family
//   ST_*      : wave_meas FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package wave_pkg;

   localparam int SAMPLE_W = 14;

   typedef logic [SAMPLE_W-1:0] sample_t;

   localparam sample_t MIDSCALE = 14'd8192;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_REPORT  = 2'd2;

endpackage

// File: rtl/wave_meas_if.sv
// -----------------------------------------------------------------------------
// wave_meas_if
// Sample stream in, measurement results out.
//   en, sample_valid, sample            : driven by the source (master)
//   crossings, vmax, vmin, vpp,
//   result_valid, busy                  : driven by wave_meas (slave)
// -----------------------------------------------------------------------------
interface wave_meas_if
   import wave_pkg::*;
#(
   parameter int CNT_W = 16
) ();

   logic             en;
   logic             sample_valid;
   sample_t          sample;
   logic [CNT_W-1:0] crossings;
   sample_t          vmax;
   sample_t          vmin;
   sample_t          vpp;
   logic             result_valid;
   logic             busy;

   modport master (
      output en, sample_valid, sample,
      input  crossings, vmax, vmin, vpp, result_valid, busy
   );

   modport slave (
      input  en, sample_valid, sample,
      output crossings, vmax, vmin, vpp, result_valid, busy
   );

endinterface

// File: rtl/wave_meas_xing_detect.sv
// -----------------------------------------------------------------------------
// xing_detect
// Rising midscale crossing detector with a hysteresis band of +/-HYST.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clr     : synchronous clear of the armed flag (window start)
//   i_vld     : sample qualifier (already gated to MEASURE by the caller)
//   i_sample  : offset-binary sample
//   o_xing    : one-cycle strobe, combinational from the current sample
// -----------------------------------------------------------------------------
module xing_detect
   import wave_pkg::*;
#(
   parameter int HYST = 64
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    i_clr,
   input  logic    i_vld,
   input  sample_t i_sample,
   output logic    o_xing
);

   localparam sample_t LO_THR = MIDSCALE - sample_t'(HYST);
   localparam sample_t HI_THR = MIDSCALE + sample_t'(HYST);

   logic r_armed;
   logic w_below;
   logic w_above;

   assign w_below = (i_sample <  LO_THR);
   assign w_above = (i_sample >= HI_THR);

   // Strobe is combinational so the caller can fold it into the same cycle's
   // running count, including the final sample of a window.
   assign o_xing = i_vld & r_armed & w_above;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed <= 1'b0;
      end else if (i_clr) begin
         r_armed <= 1'b0;
      end else if (i_vld) begin
         if (w_below)
            r_armed <= 1'b1;
         else if (o_xing)
            r_armed <= 1'b0;
      end
   end

endmodule

// File: rtl/wave_meas.sv
// -----------------------------------------------------------------------------
// wave_meas
// Gated-window waveform measurement: counts rising midscale crossings (with
// hysteresis) and tracks min/max over GATE_CYCLES clocks, then publishes one
// result set per window with a one-cycle result_valid pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wave_meas_if.slave
//              in : en, sample_valid, sample
//              out: crossings, vmax, vmin, vpp, result_valid, busy
// -----------------------------------------------------------------------------
module wave_meas
   import wave_pkg::*;
#(
   parameter int GATE_CYCLES = 4096,
   parameter int HYST        = 64,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst,
   wave_meas_if.slave  bus
);

   localparam int                 WIN_W    = $clog2(GATE_CYCLES);
   localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(GATE_CYCLES - 1);
   localparam logic [WIN_W-1:0]   WIN_ONE  = WIN_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   // Saturating increment: the crossing count sticks at all-ones.
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt,
                                                  input logic             inc);
      if (inc && (cnt != CNT_MAX))
         return cnt + CNT_ONE;
      return cnt;
   endfunction

   // Peak-to-peak clamps to 0 for an empty window (max=0, min=all-ones).
   function automatic sample_t f_vpp(input sample_t mx, input sample_t mn);
      if (mx >= mn)
         return mx - mn;
      return '0;
   endfunction

   logic [1:0]       r_state;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_cnt;
   sample_t          r_max;
   sample_t          r_min;

   logic [CNT_W-1:0] r_crossings;
   sample_t          r_vmax;
   sample_t          r_vmin;
   sample_t          r_vpp;
   logic             r_rvld;

   logic             w_in_meas;
   logic             w_smp;
   logic             w_clr;
   logic             w_last;
   logic             w_xing;
   logic [CNT_W-1:0] w_cnt_nxt;
   sample_t          w_max_nxt;
   sample_t          w_min_nxt;

   assign w_in_meas = (r_state == ST_MEASURE) && bus.en;
   assign w_smp     = w_in_meas && bus.sample_valid;
   // Window start: leaving IDLE or REPORT with en held high.
   assign w_clr     = (r_state != ST_MEASURE) && bus.en;
   assign w_last    = w_in_meas && (r_win_cnt == WIN_LAST);

   xing_detect #(
      .HYST (HYST)
   ) u_xing (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .i_vld    (w_smp),
      .i_sample (bus.sample),
      .o_xing   (w_xing)
   );

   assign w_cnt_nxt = f_sat_inc(r_cnt, w_xing);
   assign w_max_nxt = (w_smp && (bus.sample > r_max)) ? bus.sample : r_max;
   assign w_min_nxt = (w_smp && (bus.sample < r_min)) ? bus.sample : r_min;

   // The result registers load on the edge that ends the final MEASURE cycle,
   // using the running values already merged with that cycle's sample, so
   // the published set and result_valid are visible during the REPORT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_win_cnt   <= '0;
         r_cnt       <= '0;
         r_max       <= '0;
         r_min       <= '1;
         r_crossings <= '0;
         r_vmax      <= '0;
         r_vmin      <= '0;
         r_vpp       <= '0;
         r_rvld      <= 1'b0;
      end else begin
         r_rvld <= 1'b0;
         case (r_state)
            ST_IDLE, ST_REPORT: begin
               if (bus.en) begin
                  r_state   <= ST_MEASURE;
                  r_win_cnt <= '0;
                  r_cnt     <= '0;
                  r_max     <= '0;
                  r_min     <= '1;
               end else begin
                  r_state   <= ST_IDLE;
               end
            end
            ST_MEASURE: begin
               if (!bus.en) begin
                  // Partial window is discarded; published results hold.
                  r_state <= ST_IDLE;
               end else begin
                  r_win_cnt <= r_win_cnt + WIN_ONE;
                  r_cnt     <= w_cnt_nxt;
                  r_max     <= w_max_nxt;
                  r_min     <= w_min_nxt;
                  if (w_last) begin
                     r_state     <= ST_REPORT;
                     r_crossings <= w_cnt_nxt;
                     r_vmax      <= w_max_nxt;
                     r_vmin      <= w_min_nxt;
                     r_vpp       <= f_vpp(w_max_nxt, w_min_nxt);
                     r_rvld      <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.crossings    = r_crossings;
   assign bus.vmax         = r_vmax;
   assign bus.vmin         = r_vmin;
   assign bus.vpp          = r_vpp;
   assign bus.result_valid = r_rvld;
   assign bus.busy         = (r_state == ST_MEASURE);

endmodule

// File: tb/tb_wave_meas.sv
// -----------------------------------------------------------------------------
// tb_wave_meas
// Directed bench for wave_meas: a GATE_CYCLES=4096 instance for the main
// scenarios and a GATE_CYCLES=64, CNT_W=4 instance for counter saturation.
// -----------------------------------------------------------------------------
module tb_wave_meas;
   import wave_pkg::*;

   localparam int M_SQUARE = 0;
   localparam int M_NOISE  = 1;
   localparam int M_EMPTY  = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   wave_meas_if #(.CNT_W(16)) bif ();
   wave_meas_if #(.CNT_W(4))  sif ();

   wave_meas #(.GATE_CYCLES(4096), .HYST(64), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   wave_meas #(.GATE_CYCLES(64), .HYST(64), .CNT_W(4)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   int errors = 0;
   int checks = 0;

   function automatic sample_t pat(input int mode, input int k);
      case (mode)
         M_SQUARE: return ((k % 16) < 8) ? 14'd8000 : 14'd8400;
         M_NOISE:  return ((k % 2) == 0) ? 14'd8232 : 14'd8152;
         default:  return 14'd8192;
      endcase
   endfunction

   // From IDLE: raise en, step into MEASURE (window count 0).
   task automatic start_main();
      bif.en           = 1'b1;
      bif.sample_valid = 1'b0;
      bif.sample       = 14'd8192;
      @(posedge clk); #1;
   endtask

   // Present one window of pattern samples until result_valid or timeout.
   task automatic run_main(input int mode, output int kdone, output bit got);
      got   = 1'b0;
      kdone = -1;
      for (int k = 0; k < 4200; k++) begin
         bif.sample       = pat(mode, k);
         bif.sample_valid = (mode != M_EMPTY);
         @(posedge clk); #1;
         if (bif.result_valid) begin
            got   = 1'b1;
            kdone = k;
            return;
         end
      end
   endtask

   // From REPORT: drop en and return to IDLE.
   task automatic finish_main();
      bif.en           = 1'b0;
      bif.sample_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bif.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL pulse_width result_valid=%0b expected 0", bif.result_valid);
      end
   endtask

   task automatic test_reset();
      rst              = 1'b1;
      bif.en           = 1'b0;
      bif.sample_valid = 1'b0;
      bif.sample       = '0;
      sif.en           = 1'b0;
      sif.sample_valid = 1'b0;
      sif.sample       = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bif.crossings, bif.vmax, bif.vmin, bif.vpp} !== '0) begin
         errors++;
         $display("FAIL reset_outputs cross=%0d vmax=%0d vmin=%0d vpp=%0d expected all 0",
                  bif.crossings, bif.vmax, bif.vmin, bif.vpp);
      end
      checks++;
      if ({bif.result_valid, bif.busy, sif.busy, sif.result_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl rvld=%0b busy=%0b expected 0 0", bif.result_valid, bif.busy);
      end
   endtask

   task automatic test_square();
      int k;
      bit got;
      start_main();
      checks++;
      if (bif.busy !== 1'b1) begin
         errors++;
         $display("FAIL square_busy busy=%0b expected 1", bif.busy);
      end
      run_main(M_SQUARE, k, got);
      checks++;
      if (!got || k != 4095) begin
         errors++;
         $display("FAIL square_latency got=%0b last_k=%0d expected pulse after k=4095", got, k);
      end
      checks++;
      if (bif.crossings !== 16'd256) begin
         errors++;
         $display("FAIL square_crossings got=%0d expected 256", bif.crossings);
      end
      checks++;
      if (bif.vmax !== 14'd8400 || bif.vmin !== 14'd8000) begin
         errors++;
         $display("FAIL square_minmax vmax=%0d vmin=%0d expected 8400 8000", bif.vmax, bif.vmin);
      end
      checks++;
      if (bif.vpp !== 14'd400) begin
         errors++;
         $display("FAIL square_vpp got=%0d expected 400", bif.vpp);
      end
      checks++;
      if (bif.busy !== 1'b0) begin
         errors++;
         $display("FAIL report_busy busy=%0b expected 0", bif.busy);
      end
   endtask

   // en stays high through REPORT; a full-scale sample offered in the REPORT
   // cycle must not reach the next window.
   task automatic test_back_to_back();
      int k;
      bit got;
      bif.sample       = 14'd16383;
      bif.sample_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bif.busy !== 1'b1 || bif.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_restart busy=%0b rvld=%0b expected 1 0", bif.busy, bif.result_valid);
      end
      run_main(M_NOISE, k, got);
      checks++;
      if (!got || k != 4095) begin
         errors++;
         $display("FAIL noise_latency got=%0b last_k=%0d expected pulse after k=4095", got, k);
      end
      checks++;
      if (bif.crossings !== 16'd0) begin
         errors++;
         $display("FAIL noise_crossings got=%0d expected 0", bif.crossings);
      end
      checks++;
      if (bif.vmax !== 14'd8232 || bif.vmin !== 14'd8152) begin
         errors++;
         $display("FAIL noise_minmax vmax=%0d vmin=%0d expected 8232 8152", bif.vmax, bif.vmin);
      end
      checks++;
      if (bif.vpp !== 14'd80) begin
         errors++;
         $display("FAIL noise_vpp got=%0d expected 80", bif.vpp);
      end
      finish_main();
   endtask

   task automatic test_en_drop();
      int pulses;
      start_main();
      for (int k = 0; k < 100; k++) begin
         bif.sample       = pat(M_SQUARE, k);
         bif.sample_valid = 1'b1;
         @(posedge clk); #1;
      end
      bif.en           = 1'b0;
      bif.sample       = 14'd16383;
      @(posedge clk); #1;
      checks++;
      if (bif.busy !== 1'b0) begin
         errors++;
         $display("FAIL endrop_busy busy=%0b expected 0", bif.busy);
      end
      pulses = 0;
      for (int k = 0; k < 4200; k++) begin
         @(posedge clk); #1;
         if (bif.result_valid) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL endrop_pulse got=%0d pulses expected 0", pulses);
      end
      checks++;
      if (bif.crossings !== 16'd0 || bif.vmax !== 14'd8232 ||
          bif.vmin !== 14'd8152 || bif.vpp !== 14'd80) begin
         errors++;
         $display("FAIL endrop_hold cross=%0d vmax=%0d vmin=%0d vpp=%0d expected 0 8232 8152 80",
                  bif.crossings, bif.vmax, bif.vmin, bif.vpp);
      end
      bif.sample_valid = 1'b0;
   endtask

   task automatic test_empty();
      int k;
      int pulses;
      bit got;
      start_main();
      run_main(M_EMPTY, k, got);
      checks++;
      if (!got || k != 4095) begin
         errors++;
         $display("FAIL empty_latency got=%0b last_k=%0d expected pulse after k=4095", got, k);
      end
      checks++;
      if (bif.crossings !== 16'd0 || bif.vmax !== 14'd0) begin
         errors++;
         $display("FAIL empty_cross_vmax cross=%0d vmax=%0d expected 0 0", bif.crossings, bif.vmax);
      end
      checks++;
      if (bif.vmin !== 14'h3FFF) begin
         errors++;
         $display("FAIL empty_vmin got=%0d expected 16383", bif.vmin);
      end
      checks++;
      if (bif.vpp !== 14'd0) begin
         errors++;
         $display("FAIL empty_vpp got=%0d expected 0", bif.vpp);
      end
      finish_main();
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bif.result_valid) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL empty_single_pulse extra=%0d expected 0", pulses);
      end
   endtask

   task automatic test_saturation();
      int  kdone;
      bit  got;
      got   = 1'b0;
      kdone = -1;
      sif.en           = 1'b1;
      sif.sample_valid = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 100; k++) begin
         sif.sample       = ((k % 2) == 0) ? 14'd0 : 14'd16383;
         sif.sample_valid = 1'b1;
         @(posedge clk); #1;
         if (sif.result_valid) begin
            got   = 1'b1;
            kdone = k;
            break;
         end
      end
      checks++;
      if (!got || kdone != 63) begin
         errors++;
         $display("FAIL sat_latency got=%0b last_k=%0d expected pulse after k=63", got, kdone);
      end
      checks++;
      if (sif.crossings !== 4'd15) begin
         errors++;
         $display("FAIL sat_crossings got=%0d expected 15", sif.crossings);
      end
      checks++;
      if (sif.vmax !== 14'd16383 || sif.vmin !== 14'd0 || sif.vpp !== 14'd16383) begin
         errors++;
         $display("FAIL sat_minmax vmax=%0d vmin=%0d vpp=%0d expected 16383 0 16383",
                  sif.vmax, sif.vmin, sif.vpp);
      end
      sif.en           = 1'b0;
      sif.sample_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      start_main();
      for (int k = 0; k < 50; k++) begin
         bif.sample       = pat(M_SQUARE, k);
         bif.sample_valid = 1'b1;
         @(posedge clk); #1;
      end
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bif.crossings, bif.vmax, bif.vmin, bif.vpp} !== '0 ||
          {sif.crossings, sif.vmax, sif.vmin, sif.vpp} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs vmin=%0d sat_vmax=%0d expected 0 0", bif.vmin, sif.vmax);
      end
      checks++;
      if (bif.busy !== 1'b0 || bif.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ctrl busy=%0b rvld=%0b expected 0 0", bif.busy, bif.result_valid);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bif.busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_resume busy=%0b expected 1", bif.busy);
      end
      bif.en           = 1'b0;
      bif.sample_valid = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_square();
      test_back_to_back();
      test_en_drop();
      test_empty();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
